// File: rtl/dreg_pipe_chain.sv
// +--------------------------------------------------------------------------+
// | dreg_pipe_chain: DEPTH-stage pipeline with per-stage stall/flush, valid   |
// | bits and bubble insertion. Optional counters under PIPE_PERF_CNT_EN.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module dreg_pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [DEPTH-1:0]           stall,
  input  logic [DEPTH-1:0]           flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [OCC_W-1:0] occ_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // A stall anywhere downstream freezes this stage too.
      assign hold[gi] = |stall[DEPTH-1:gi];

      if (gi == 0) begin : g_head
        always_comb begin
          valid_d[gi] = valid_q[gi];
          data_d[gi]  = data_q[gi];
          if (flush[gi]) begin
            valid_d[gi] = 1'b0;
            data_d[gi]  = '0;
          end else if (!hold[gi]) begin
            valid_d[gi] = in_valid;
            data_d[gi]  = in_data;
          end
        end
      end else begin : g_body
        always_comb begin
          valid_d[gi] = valid_q[gi];
          data_d[gi]  = data_q[gi];
          if (flush[gi]) begin
            valid_d[gi] = 1'b0;
            data_d[gi]  = '0;
          end else if (!hold[gi]) begin
            if (hold[gi-1]) begin
              valid_d[gi] = 1'b0;
              data_d[gi]  = '0;
            end else begin
              valid_d[gi] = valid_q[gi-1];
              data_d[gi]  = data_q[gi-1];
            end
          end
        end
      end
    end
  endgenerate

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      occupancy <= occ_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid   = valid_q[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign stage_valid = valid_q;

`ifdef PIPE_PERF_CNT_EN
  localparam int SUM_W = CNT_W + OCC_W;

  logic [OCC_W-1:0] killed;
  logic [SUM_W-1:0] flush_sum;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_comb begin
    killed = '0;
    for (int i = 0; i < DEPTH; i++) begin
      killed = killed + OCC_W'(flush[i] & valid_q[i]);
    end
    flush_sum = SUM_W'(flush_cnt_q) + SUM_W'(killed);
  end

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (|stall && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_sum > SUM_W'({CNT_W{1'b1}})) begin
        flush_cnt_q <= {CNT_W{1'b1}};
      end else begin
        flush_cnt_q <= flush_sum[CNT_W-1:0];
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dreg_pipe_chain.sv
// +--------------------------------------------------------------------------+
// | tb_dreg_pipe_chain: randomized and directed bench for dreg_pipe_chain.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dreg_pipe_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [DEPTH-1:0] stall;
  logic [DEPTH-1:0] flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH-1:0] stage_valid;
  logic [2:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  // Reference: contents of each slot plus counter totals.
  bit               m_v [DEPTH];
  logic [WIDTH-1:0] m_d [DEPTH];
  int               m_sc;
  int               m_fc;

  dreg_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_data(out_data),
    .stage_valid(stage_valid), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 0;
      m_d[i] = '0;
    end
    m_sc = 0;
    m_fc = 0;
  endfunction

  function automatic void model_step();
    bit               nv [DEPTH];
    logic [WIDTH-1:0] nd [DEPTH];
    bit               h  [DEPTH];
    int               killed = 0;
    for (int i = 0; i < DEPTH; i++) begin
      h[i] = 0;
      for (int j = i; j < DEPTH; j++) if (stall[j]) h[i] = 1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      nv[i] = 0;
      nd[i] = '0;
      if (flush[i]) begin
        if (m_v[i]) killed++;
      end else if (h[i]) begin
        nv[i] = m_v[i];
        nd[i] = m_d[i];
      end else if (i == 0) begin
        nv[i] = in_valid;
        nd[i] = in_data;
      end else if (!h[i-1]) begin
        nv[i] = m_v[i-1];
        nd[i] = m_d[i-1];
      end
    end
`ifdef PIPE_PERF_CNT_EN
    if (stall != '0) m_sc = (m_sc + 1 > CMAX) ? CMAX : m_sc + 1;
    m_fc = (m_fc + killed > CMAX) ? CMAX : m_fc + killed;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = nv[i];
      m_d[i] = nd[i];
    end
  endfunction

  function automatic logic [DEPTH-1:0] m_sv();
    logic [DEPTH-1:0] v = '0;
    for (int i = 0; i < DEPTH; i++) v[i] = m_v[i];
    return v;
  endfunction

  function automatic logic [2:0] m_occ();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_v[i]);
    return 3'(n);
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic fill(input int base);
    stall = '0; flush = '0; in_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      in_data = WIDTH'(base + k);
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; stall = '0; flush = '0;
    model_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    checks++; if (stage_valid !== '0) begin errors++; $display("FAIL reset_stage_valid got %b exp 0", stage_valid); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = WIDTH'(k);
      step();
      checks++; if (out_valid !== m_v[DEPTH-1] || out_data !== m_d[DEPTH-1]) begin
        errors++; $display("FAIL stream_out cyc %0d got %b/%0d exp %b/%0d", k, out_valid, out_data, m_v[DEPTH-1], m_d[DEPTH-1]);
      end
      if (k == DEPTH) begin
        checks++; if (out_data !== 32'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL stream_latency got %b/%0d exp 1/1", out_valid, out_data); end
      end
    end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL stream_occupancy got %0d exp 4", occupancy); end
  endtask

  task automatic test_stall();
    fill(1);
    stall = 4'b0100; in_data = 32'd99;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL stall_bubble got %b/%0d exp 0/0", out_valid, out_data); end
      checks++; if (stage_valid !== 4'b0111) begin errors++; $display("FAIL stall_stages got %b exp 0111", stage_valid); end
    end
    stall = '0; in_data = 32'd5;
    step();
    checks++; if (out_data !== 32'd2 || out_data !== m_d[DEPTH-1]) begin errors++; $display("FAIL stall_resume got %0d exp 2", out_data); end
    step();
    checks++; if (out_data !== 32'd3) begin errors++; $display("FAIL stall_lost_input got %0d exp 3", out_data); end
  endtask

  task automatic test_flush();
    int fc0;
    fill(10);
    fc0 = m_fc;
    flush = 4'b0011;
    step();
    flush = '0;
    checks++; if (stage_valid !== 4'b1100) begin errors++; $display("FAIL flush_stages got %b exp 1100", stage_valid); end
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL flush_occupancy got %0d exp 2", occupancy); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (32'(flush_cnt) !== 32'((fc0 + 2 > CMAX) ? CMAX : fc0 + 2)) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", flush_cnt, (fc0 + 2 > CMAX) ? CMAX : fc0 + 2); end
`else
    checks++; if (flush_cnt !== '0) begin errors++; $display("FAIL flush_cnt got %0d exp 0 (fc0 %0d)", flush_cnt, fc0); end
`endif
  endtask

  task automatic test_flush_stall();
    int sc0;
    fill(20);
    sc0 = m_sc;
    flush = 4'b0010; stall = 4'b1000;
    step();
    flush = '0; stall = '0;
    checks++; if (stage_valid !== 4'b1101) begin errors++; $display("FAIL fs_stages got %b exp 1101", stage_valid); end
    checks++; if (out_data !== 32'd20) begin errors++; $display("FAIL fs_out_held got %0d exp 20", out_data); end
    checks++; if (stall_cnt !== 4'(m_sc) || m_sc < sc0) begin errors++; $display("FAIL fs_stall_cnt got %0d exp %0d", stall_cnt, m_sc); end
  endtask

  task automatic test_reset_mid();
    int n;
    fill(30);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (out_valid !== 1'b0 || stage_valid !== '0 || occupancy !== '0) begin
      errors++; $display("FAIL midreset_clear got %b/%b/%0d exp 0/0/0", out_valid, stage_valid, occupancy);
    end
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL midreset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h55;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (out_valid === 1'b1) begin n = k; break; end
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL midreset_latency got %0d exp %0d", n, DEPTH); end
  endtask

  task automatic test_saturate();
    stall = 4'b0001; in_valid = 1'b0;
    for (int k = 0; k < 20; k++) step();
    stall = '0;
`ifdef PIPE_PERF_CNT_EN
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL stall_sat got %0d exp 15", stall_cnt); end
`else
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL stall_sat got %0d exp 0", stall_cnt); end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom);
      in_data  = $urandom;
      stall    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
      flush    = ($urandom_range(0, 4) == 0) ? 4'($urandom) : '0;
      step();
      checks++; if (out_valid !== m_v[DEPTH-1] || out_data !== m_d[DEPTH-1]) begin
        errors++; $display("FAIL rand_out cyc %0d got %b/%h exp %b/%h", k, out_valid, out_data, m_v[DEPTH-1], m_d[DEPTH-1]);
      end
      checks++; if (stage_valid !== m_sv() || occupancy !== m_occ()) begin
        errors++; $display("FAIL rand_valid cyc %0d got %b/%0d exp %b/%0d", k, stage_valid, occupancy, m_sv(), m_occ());
      end
      checks++; if (stall_cnt !== 4'(m_sc) || flush_cnt !== 4'(m_fc)) begin
        errors++; $display("FAIL rand_cnt cyc %0d got %0d/%0d exp %0d/%0d", k, stall_cnt, flush_cnt, m_sc, m_fc);
      end
    end
    stall = '0; flush = '0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_stall();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
